// File: rtl/est_pkg.sv
// Shared receiver package: estimator sequencer state encoding, default sizing and the
// symbol-number helper used by the slot-order tracker.
package est_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClr,
    StRun,
    StHold
  } est_state_e;

  localparam int unsigned NScDefault      = 12;
  localparam logic [2:0]  PilotSymDefault = 3'd4;
  localparam logic [2:0]  SymIllegal      = 3'd7;

  // Symbols in a slot run 0..6, so the successor wraps at 6.
  function automatic logic [2:0] next_sym(input logic [2:0] sym);
    return (sym == 3'd6) ? 3'd0 : sym + 3'd1;
  endfunction

endpackage

// File: rtl/sc_counter.sv
// Subcarrier index counter.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   clr_i   : synchronous clear (priority over en_i)
//   en_i    : increment enable
//   count_o : current index (registered)
//   tc_o    : high while count_o equals Last
module sc_counter #(
  parameter int unsigned Width = 4,
  parameter int unsigned Last  = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == Width'(Last));

endmodule

// File: rtl/est_seq_ctrl.sv
// Channel-estimate sequencer. A pilot symbol clears the serial-to-parallel buffer, then
// steps the multiplier input mux across all subcarriers while capturing each product,
// and finally holds the completed estimate set until the equalizer acknowledges it.
// Also tracks slot symbol order and flags overruns.
//   i_clk_est    : clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_sym_valid  : one-cycle strobe, new received symbol
//   i_symbol_num : symbol number in slot, qualified by i_sym_valid
//   i_eq_ready   : equalizer has taken the estimate set
//   o_indx       : subcarrier select for the multiplier input mux
//   o_wr_en      : serial-to-parallel capture enable
//   o_clr        : serial-to-parallel buffer clear
//   o_est_done   : per-subcarrier thermometer of captured estimates
//   o_est_valid  : full estimate set stable
//   o_busy       : clearing or running
//   o_overrun    : sticky, pilot arrived while busy / unacknowledged
//   o_seq_err    : sticky, out-of-order or illegal symbol number
// Every output is a flop; flag flops are loaded from the next-state decode.
module est_seq_ctrl
  import est_pkg::*;
#(
  parameter int unsigned N_SC      = NScDefault,
  parameter logic [2:0]  PILOT_SYM = PilotSymDefault,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             i_clk_est,
  input  logic             i_rst,
  input  logic             i_sym_valid,
  input  logic [2:0]       i_symbol_num,
  input  logic             i_eq_ready,
  output logic [IDX_W-1:0] o_indx,
  output logic             o_wr_en,
  output logic             o_clr,
  output logic [N_SC-1:0]  o_est_done,
  output logic             o_est_valid,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_seq_err
);

  est_state_e state_d, state_q;

  logic             pilot;
  logic             overrun_set;
  logic [IDX_W-1:0] cnt;
  logic             cnt_tc;
  logic             cnt_clr;
  logic             cnt_en;

  logic [N_SC-1:0] done_d, done_q;
  logic            wr_en_d, wr_en_q;
  logic            clr_d, clr_q;
  logic            valid_d, valid_q;
  logic            busy_d, busy_q;
  logic            overrun_q;
  logic            seq_err_d, seq_err_q;
  logic [2:0]      exp_d, exp_q;
  logic            armed_d, armed_q;

  assign pilot = i_sym_valid && (i_symbol_num == PILOT_SYM);

  // Counter sits at zero outside RUN, so it directly drives o_indx.
  assign cnt_clr = (state_d != StRun);
  assign cnt_en  = (state_q == StRun);

  sc_counter #(
    .Width (IDX_W),
    .Last  (N_SC - 1)
  ) u_sc_counter (
    .clk_i   (i_clk_est),
    .rst_i   (i_rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    overrun_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pilot) state_d = StClr;
      end
      StClr: begin
        state_d     = StRun;
        overrun_set = pilot;
      end
      StRun: begin
        overrun_set = pilot;
        if (cnt_tc) state_d = StHold;
      end
      StHold: begin
        // A pilot restarts estimation; it only counts as overrun if the old set
        // was never acknowledged.
        if (pilot) begin
          state_d     = StClr;
          overrun_set = !i_eq_ready;
        end else if (i_eq_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_d = done_q;
    if (state_d == StClr) begin
      done_d = '0;
    end else if (state_q == StRun) begin
      for (int unsigned i = 0; i < N_SC; i++) begin
        if (cnt == IDX_W'(i)) done_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_en_d = (state_d == StRun);
    clr_d   = (state_d == StClr);
    valid_d = (state_d == StHold);
    busy_d  = (state_d == StClr) || (state_d == StRun);
  end

  // Slot order tracker. After a mismatch it resynchronises to the received number so a
  // single dropped symbol is reported once; an illegal 7 disarms it until the next legal
  // symbol.
  always_comb begin
    exp_d     = exp_q;
    armed_d   = armed_q;
    seq_err_d = seq_err_q;
    if (i_sym_valid) begin
      if (i_symbol_num == SymIllegal) begin
        seq_err_d = 1'b1;
        armed_d   = 1'b0;
      end else begin
        if (armed_q && (i_symbol_num != exp_q)) seq_err_d = 1'b1;
        exp_d   = next_sym(i_symbol_num);
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_est) begin
    if (i_rst) begin
      state_q   <= StIdle;
      done_q    <= '0;
      wr_en_q   <= 1'b0;
      clr_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      seq_err_q <= 1'b0;
      exp_q     <= 3'd0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      clr_q     <= clr_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_q | overrun_set;
      seq_err_q <= seq_err_d;
      exp_q     <= exp_d;
      armed_q   <= armed_d;
    end
  end

  assign o_indx      = cnt;
  assign o_wr_en     = wr_en_q;
  assign o_clr       = clr_q;
  assign o_est_done  = done_q;
  assign o_est_valid = valid_q;
  assign o_busy      = busy_q;
  assign o_overrun   = overrun_q;
  assign o_seq_err   = seq_err_q;

endmodule

// File: tb/tb_est_seq_ctrl.sv
// Bench for est_seq_ctrl: directed symbol stimulus, cycle-tagged expected snapshots held
// in a scoreboard queue, compared by an independent monitor on the falling edge.
module tb_est_seq_ctrl;

  localparam int Never = 1 << 30;
  localparam int Big   = 1 << 30;
  localparam int NSc   = 12;

  typedef struct {
    int          cyc;
    string       tag;
    logic [3:0]  indx;
    logic        wr_en;
    logic        clr;
    logic [11:0] done;
    logic        valid;
    logic        busy;
    logic        ovr;
    logic        serr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sym_valid;
  logic [2:0]  symbol_num;
  logic        eq_ready;
  logic [3:0]  indx;
  logic        wr_en;
  logic        clr;
  logic [11:0] est_done;
  logic        est_valid;
  logic        busy;
  logic        overrun;
  logic        seq_err;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  est_seq_ctrl dut (
    .i_clk_est    (clk),
    .i_rst        (rst),
    .i_sym_valid  (sym_valid),
    .i_symbol_num (symbol_num),
    .i_eq_ready   (eq_ready),
    .o_indx       (indx),
    .o_wr_en      (wr_en),
    .o_clr        (clr),
    .o_est_done   (est_done),
    .o_est_valid  (est_valid),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_seq_err    (seq_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d required finish before timeout", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: pops every expectation due in the current cycle (or overdue) and compares.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if ((sb[i].cyc != cyc) ||
            ({indx, wr_en, clr, est_done, est_valid, busy, overrun, seq_err} !==
             {sb[i].indx, sb[i].wr_en, sb[i].clr, sb[i].done, sb[i].valid, sb[i].busy,
              sb[i].ovr, sb[i].serr})) begin
          errors++;
          $display({"FAIL %s cyc=%0d/%0d got indx=%0d wr=%b clr=%b done=%h val=%b busy=%b ",
                    "ovr=%b serr=%b want indx=%0d wr=%b clr=%b done=%h val=%b busy=%b ",
                    "ovr=%b serr=%b"},
                   sb[i].tag, cyc, sb[i].cyc, indx, wr_en, clr, est_done, est_valid, busy,
                   overrun, seq_err, sb[i].indx, sb[i].wr_en, sb[i].clr, sb[i].done,
                   sb[i].valid, sb[i].busy, sb[i].ovr, sb[i].serr);
        end
        sb.delete(i);
      end
    end
  end

  task automatic check(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s cyc=%0d", tag, cyc);
    end
  endtask

  task automatic push(input int c, input string tag, input logic [3:0] ix, input logic we,
                      input logic cl, input logic [11:0] dn, input logic vl, input logic bs,
                      input logic ov, input logic se);
    exp_t e;
    e.cyc = c; e.tag = tag; e.indx = ix; e.wr_en = we; e.clr = cl; e.done = dn;
    e.valid = vl; e.busy = bs; e.ovr = ov; e.serr = se;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int c, input string tag, input logic [11:0] dn,
                           input logic ov, input logic se);
    push(c, tag, 4'd0, 1'b0, 1'b0, dn, 1'b0, 1'b0, ov, se);
  endtask

  task automatic push_hold(input int c, input string tag, input logic ov, input logic se);
    push(c, tag, 4'd0, 1'b0, 1'b0, 12'hfff, 1'b1, 1'b0, ov, se);
  endtask

  // Full pilot sequence for a strobe at cycle t: CLR at t+1, RUN t+2..t+1+NSc, HOLD after.
  task automatic push_seq(input int t, input string tag, input int ovr_cyc, input int serr_cyc,
                          input int upto);
    logic [11:0] d;
    int          k;
    for (int c = t + 1; (c <= t + 2 + NSc) && (c <= upto); c++) begin
      if (c == t + 1) begin
        push(c, tag, 4'd0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, c >= ovr_cyc, c >= serr_cyc);
      end else if (c <= t + 1 + NSc) begin
        k = c - t - 2;
        d = '0;
        for (int j = 0; j < k; j++) d[j] = 1'b1;
        push(c, tag, 4'(k), 1'b1, 1'b0, d, 1'b0, 1'b1, c >= ovr_cyc, c >= serr_cyc);
      end else begin
        push_hold(c, tag, c >= ovr_cyc, c >= serr_cyc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic sym(input int c, input logic [2:0] n);
    wait_until(c);
    sym_valid  = 1'b1;
    symbol_num = n;
    tick();
    sym_valid  = 1'b0;
  endtask

  task automatic set_ready(input int c, input logic r);
    wait_until(c);
    eq_ready = r;
  endtask

  task automatic set_rst(input int c, input logic r);
    wait_until(c);
    rst = r;
  endtask

  // Fills in 5,6,0,1,2,3 so the following pilot (4) is in slot order.
  task automatic fill_to_pilot(input int c);
    logic [2:0] s [6];
    s = '{3'd5, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3};
    for (int i = 0; i < 6; i++) sym(c + i, s[i]);
  endtask

  initial begin
    rst        = 1'b1;
    sym_valid  = 1'b0;
    symbol_num = 3'd0;
    eq_ready   = 1'b0;

    // Basic pilot sequence, hold with late acknowledge, non-pilot in hold.
    push_idle(2, "reset", 12'h000, 1'b0, 1'b0);
    push_idle(9, "idle_pre", 12'h000, 1'b0, 1'b0);
    push_seq(10, "pilot", Never, Never, Big);
    for (int c = 25; c <= 29; c++) push_hold(c, "hold_wait", 1'b0, 1'b0);
    push_idle(30, "ready_release", 12'hfff, 1'b0, 1'b0);
    tick();
    check("reset_state",
          {indx, wr_en, clr, est_done, est_valid, busy, overrun, seq_err} === '0);
    set_rst(2, 1'b0);
    sym(10, 3'd4);
    sym(26, 3'd5);
    set_ready(29, 1'b1);
    set_ready(30, 1'b0);
    set_rst(31, 1'b1);

    // Pilot in HOLD with ready=1 (no overrun), then pilot in HOLD with ready=0.
    push_idle(32, "reset_idle", 12'h000, 1'b0, 1'b0);
    set_rst(32, 1'b0);
    push_seq(33, "pilot2", Never, Never, Big);
    for (int c = 48; c <= 53; c++) push_hold(c, "hold2", 1'b0, 1'b0);
    push_seq(53, "hold_ready_pilot", Never, Never, Big);
    for (int c = 68; c <= 73; c++) push_hold(c, "hold3", 1'b0, 1'b0);
    push_seq(73, "hold_overrun", 74, Never, Big);
    push_idle(88, "idle_after_ovr", 12'hfff, 1'b1, 1'b0);
    sym(33, 3'd4);
    fill_to_pilot(47);
    set_ready(53, 1'b1);
    sym(53, 3'd4);
    eq_ready = 1'b0;
    fill_to_pilot(67);
    sym(73, 3'd4);
    set_ready(87, 1'b1);
    set_ready(88, 1'b0);
    set_rst(89, 1'b1);

    // Second pilot while RUN presents index 5.
    push_idle(90, "reset2", 12'h000, 1'b0, 1'b0);
    set_rst(90, 1'b0);
    push_seq(91, "run_overrun", 99, Never, Big);
    push_idle(106, "idle3", 12'hfff, 1'b1, 1'b0);
    sym(91, 3'd4);
    fill_to_pilot(92);
    sym(98, 3'd4);
    set_ready(105, 1'b1);
    set_ready(106, 1'b0);

    // Reset while RUN presents index 7.
    push_seq(112, "mid_run", 0, Never, 121);
    push_idle(122, "mid_run_reset", 12'h000, 1'b0, 1'b0);
    push_idle(123, "post_reset_idle", 12'h000, 1'b0, 1'b0);
    fill_to_pilot(106);
    sym(112, 3'd4);
    set_rst(121, 1'b1);
    set_rst(122, 1'b0);

    // Sequence errors: 0,1,2,4 then an illegal 7.
    push_idle(127, "seq_pre", 12'h000, 1'b0, 1'b0);
    push_seq(127, "seq_gap", Never, 128, Big);
    push_idle(142, "seq_idle", 12'hfff, 1'b0, 1'b1);
    sym(124, 3'd0);
    sym(125, 3'd1);
    sym(126, 3'd2);
    sym(127, 3'd4);
    set_ready(141, 1'b1);
    set_ready(142, 1'b0);
    set_rst(143, 1'b1);
    push_idle(144, "reset3", 12'h000, 1'b0, 1'b0);
    push_idle(146, "sym7", 12'h000, 1'b0, 1'b1);
    push_idle(147, "sym7_sticky", 12'h000, 1'b0, 1'b1);
    set_rst(144, 1'b0);
    sym(145, 3'd7);
    wait_until(150);

    check("scoreboard_drained", sb.size() == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
